decode_sequencer: RTL and testbench

DECODE_SEQUENCER -- requirements
Module: decode_sequencer

---
 rtl/decode_sequencer.sv | 161 ++++++++++++++++
 tb/tb_decode_sequencer.sv | 346 ++++++++++++++++++++++++++++++++++
 2 files changed

// File: rtl/decode_sequencer.sv
// Purpose : fetch queue feeding the decoder; holds back serializing ops until
//           the ROB drains, issues them alone, then waits for their retirement.
// Latency : a pushed entry reaches dec_insn/dec_pc one cycle later (no bypass).
// Backpressure: fetch_ready drops when the queue is full or during flush/reset;
//           uop_valid is held until uop_ready, and the head is kept until popped.
// Ports   : clk, reset (sync, active-high); flush; fetch_valid/fetch_insn/
//           fetch_pc/fetch_ready (push side); dec_insn/dec_pc out to the
//           decoder, dec_serializing/dec_must_restart back from it;
//           uop_valid/uop_ready (issue side); rob_empty; ser_retired;
//           ser_stall_cycles (perf counter).
// Config  : DECODE_SEQ_PERF_EN enables the ser_stall_cycles counter; without
//           it the output is tied to zero.
module decode_sequencer #(
  parameter int QDEPTH  = 4,
  parameter int M_WIDTH = 64
) (
  input  logic               clk,
  input  logic               reset,
  input  logic               flush,
  input  logic               fetch_valid,
  input  logic [31:0]        fetch_insn,
  input  logic [M_WIDTH-1:0] fetch_pc,
  output logic               fetch_ready,
  output logic [31:0]        dec_insn,
  output logic [M_WIDTH-1:0] dec_pc,
  input  logic               dec_serializing,
  input  logic               dec_must_restart,
  output logic               uop_valid,
  input  logic               uop_ready,
  input  logic               rob_empty,
  input  logic               ser_retired,
  output logic [31:0]        ser_stall_cycles
);

  localparam int PTR_W = $clog2(QDEPTH);
  localparam int CNT_W = PTR_W + 1;
  localparam logic [CNT_W-1:0] FULL_CNT = CNT_W'(QDEPTH);

  typedef enum logic [2:0] {
    ST_RUN       = 3'd0,
    ST_DRAIN     = 3'd1,
    ST_ISSUE_SER = 3'd2,
    ST_WAIT_SER  = 3'd3,
    ST_HALT      = 3'd4
  } state_t;

  state_t             state_q, state_d;
  logic [PTR_W-1:0]   head_q, head_d;
  logic [PTR_W-1:0]   tail_q, tail_d;
  logic [CNT_W-1:0]   count_q, count_d;

  // Payload storage is deliberately not reset; count gates what is visible.
  logic [31:0]        insn_mem [QDEPTH];
  logic [M_WIDTH-1:0] pc_mem   [QDEPTH];

  logic q_empty;
  logic push;
  logic pop;

  assign q_empty     = (count_q == '0);
  assign fetch_ready = (count_q != FULL_CNT) && !flush && !reset;
  assign push        = fetch_valid && fetch_ready;
  assign pop         = uop_valid && uop_ready;

  assign dec_insn = q_empty ? '0 : insn_mem[head_q];
  assign dec_pc   = q_empty ? '0 : pc_mem[head_q];

  // Sequencer: a serializing head waits for an empty ROB, issues alone,
  // then blocks further issue until it retires (or until flush if it
  // demands a restart).
  always_comb begin
    state_d   = state_q;
    uop_valid = 1'b0;
    case (state_q)
      ST_RUN: begin
        if (!q_empty) begin
          if (dec_serializing) state_d = ST_DRAIN;
          else                 uop_valid = 1'b1;
        end
      end
      ST_DRAIN: begin
        if (rob_empty) state_d = ST_ISSUE_SER;
      end
      ST_ISSUE_SER: begin
        uop_valid = !q_empty;
        if (!q_empty && uop_ready)
          state_d = dec_must_restart ? ST_HALT : ST_WAIT_SER;
      end
      ST_WAIT_SER: begin
        if (ser_retired) state_d = ST_RUN;
      end
      ST_HALT: begin
        state_d = ST_HALT;
      end
      default: state_d = ST_RUN;
    endcase
    // Flush (and reset) pre-empt every handshake in the same cycle.
    if (flush || reset) begin
      uop_valid = 1'b0;
      state_d   = ST_RUN;
    end
  end

  always_comb begin
    head_d  = head_q;
    tail_d  = tail_q;
    count_d = count_q;
    if (flush) begin
      head_d  = '0;
      tail_d  = '0;
      count_d = '0;
    end else begin
      if (pop)  head_d = head_q + 1'b1;
      if (push) tail_d = tail_q + 1'b1;
      if (push && !pop)      count_d = count_q + 1'b1;
      else if (pop && !push) count_d = count_q - 1'b1;
    end
  end

  always_ff @(posedge clk) begin
    if (reset) begin
      state_q <= ST_RUN;
      head_q  <= '0;
      tail_q  <= '0;
      count_q <= '0;
    end else begin
      state_q <= state_d;
      head_q  <= head_d;
      tail_q  <= tail_d;
      count_q <= count_d;
    end
  end

  always_ff @(posedge clk) begin
    if (push) begin
      insn_mem[tail_q] <= fetch_insn;
      pc_mem[tail_q]   <= fetch_pc;
    end
  end

`ifdef DECODE_SEQ_PERF_EN
  logic [31:0] stall_q, stall_d;

  // Counts cycles lost waiting on the ROB or on retirement; saturates.
  always_comb begin
    stall_d = stall_q;
    if ((state_q == ST_DRAIN || state_q == ST_WAIT_SER) && stall_q != 32'hFFFF_FFFF)
      stall_d = stall_q + 32'd1;
  end

  always_ff @(posedge clk) begin
    if (reset) stall_q <= '0;
    else       stall_q <= stall_d;
  end

  assign ser_stall_cycles = stall_q;
`else
  assign ser_stall_cycles = 32'd0;
`endif

endmodule

// File: tb/tb_decode_sequencer.sv
// Purpose : self-checking bench for decode_sequencer: directed scenarios plus
//           a randomized run compared against a queue-based reference model.
// Latency : inputs change 1 time unit after the rising edge, outputs are
//           sampled at the falling edge.
// Backpressure: uop_ready / rob_empty / ser_retired are driven by the bench.
module tb_decode_sequencer;

  localparam int QD = 4;
  localparam int MW = 64;
  localparam logic [31:0] RDCYCLE = 32'hC000_2573;
  localparam logic [31:0] EBREAK  = 32'h0010_0073;
  localparam logic [31:0] NOP     = 32'h0000_0013;
`ifdef DECODE_SEQ_PERF_EN
  localparam bit PERF = 1'b1;
`else
  localparam bit PERF = 1'b0;
`endif

  logic          clk = 1'b0;
  logic          reset = 1'b1, flush = 1'b0, fetch_valid = 1'b0;
  logic [31:0]   fetch_insn = '0;
  logic [MW-1:0] fetch_pc = '0;
  logic          fetch_ready, uop_valid;
  logic [31:0]   dec_insn, ser_stall_cycles;
  logic [MW-1:0] dec_pc;
  logic          dec_serializing, dec_must_restart;
  logic          uop_ready = 1'b0, rob_empty = 1'b0, ser_retired = 1'b0;

  int n_cmp = 0;
  int n_bad = 0;

  always #5 clk = ~clk;

  // Decoder stand-in: every SYSTEM-opcode instruction serializes; ecall and
  // ebreak additionally demand a restart.
  function automatic bit is_ser(input logic [31:0] i);
    return i[6:0] == 7'h73;
  endfunction
  function automatic bit is_rst(input logic [31:0] i);
    return (i == 32'h0000_0073) || (i == EBREAK);
  endfunction

  assign dec_serializing  = is_ser(dec_insn);
  assign dec_must_restart = is_rst(dec_insn);

  decode_sequencer #(.QDEPTH(QD), .M_WIDTH(MW)) dut (
    .clk(clk), .reset(reset), .flush(flush),
    .fetch_valid(fetch_valid), .fetch_insn(fetch_insn), .fetch_pc(fetch_pc),
    .fetch_ready(fetch_ready), .dec_insn(dec_insn), .dec_pc(dec_pc),
    .dec_serializing(dec_serializing), .dec_must_restart(dec_must_restart),
    .uop_valid(uop_valid), .uop_ready(uop_ready), .rob_empty(rob_empty),
    .ser_retired(ser_retired), .ser_stall_cycles(ser_stall_cycles)
  );

  // ---------------- reference model ----------------
  typedef struct packed { logic [31:0] insn; logic [MW-1:0] pc; } ent_t;
  localparam int PH_NORMAL = 0, PH_WAIT_ROB = 1, PH_ISSUE = 2, PH_WAIT_RET = 3, PH_HALTED = 4;

  ent_t          mq[$];
  int            ph = PH_NORMAL;
  logic [31:0]   m_stall = '0;
  logic          exp_uv, exp_fr;
  logic [31:0]   exp_insn, exp_stall;
  logic [MW-1:0] exp_pc;

  function automatic void model_eval();
    exp_fr   = (mq.size() != QD) && !flush && !reset;
    exp_insn = (mq.size() > 0) ? mq[0].insn : '0;
    exp_pc   = (mq.size() > 0) ? mq[0].pc   : '0;
    exp_uv   = 1'b0;
    if (!reset && !flush && mq.size() > 0) begin
      if (ph == PH_NORMAL && !is_ser(exp_insn)) exp_uv = 1'b1;
      if (ph == PH_ISSUE) exp_uv = 1'b1;
    end
    exp_stall = PERF ? m_stall : 32'd0;
  endfunction

  function automatic void model_step();
    bit do_pop, do_push;
    if (reset) begin
      mq.delete(); ph = PH_NORMAL; m_stall = '0;
      return;
    end
    if ((ph == PH_WAIT_ROB || ph == PH_WAIT_RET) && m_stall != 32'hFFFF_FFFF)
      m_stall = m_stall + 1;
    if (flush) begin
      mq.delete(); ph = PH_NORMAL;
      return;
    end
    do_pop  = exp_uv && uop_ready;
    do_push = fetch_valid && exp_fr;
    case (ph)
      PH_NORMAL:   if (mq.size() > 0 && is_ser(exp_insn)) ph = PH_WAIT_ROB;
      PH_WAIT_ROB: if (rob_empty) ph = PH_ISSUE;
      PH_ISSUE:    if (do_pop) ph = is_rst(exp_insn) ? PH_HALTED : PH_WAIT_RET;
      PH_WAIT_RET: if (ser_retired) ph = PH_NORMAL;
      default:     ;
    endcase
    if (do_pop)  void'(mq.pop_front());
    if (do_push) mq.push_back('{fetch_insn, fetch_pc});
  endfunction

  // Apply one cycle's inputs and move to the sampling point.
  task automatic drive(input bit r, input bit f, input bit fv, input logic [31:0] ins,
                       input logic [MW-1:0] p, input bit ur, input bit re, input bit sr);
    reset = r; flush = f; fetch_valid = fv; fetch_insn = ins; fetch_pc = p;
    uop_ready = ur; rob_empty = re; ser_retired = sr;
    #4;
    model_eval();
  endtask

  task automatic tick();
    @(posedge clk);
    model_step();
    #1;
  endtask

  // ---------------- scenarios ----------------
  task automatic test_reset();
    drive(1, 0, 1, NOP, 64'h10, 1, 1, 1);
    n_cmp += 2;
    if (uop_valid !== 1'b0) begin n_bad++; $display("FAIL reset_uv0: got %b want 0", uop_valid); end
    if (fetch_ready !== 1'b0) begin n_bad++; $display("FAIL reset_fr0: got %b want 0", fetch_ready); end
    tick();
    drive(1, 1, 1, NOP, 64'h10, 1, 1, 1);
    n_cmp += 3;
    if (uop_valid !== 1'b0) begin n_bad++; $display("FAIL reset_uv1: got %b want 0", uop_valid); end
    if (fetch_ready !== 1'b0) begin n_bad++; $display("FAIL reset_fr1: got %b want 0", fetch_ready); end
    if (ser_stall_cycles !== 32'd0) begin n_bad++; $display("FAIL reset_stall: got %0d want 0", ser_stall_cycles); end
    tick();
    drive(0, 0, 0, '0, '0, 0, 0, 0);
    n_cmp += 3;
    if (fetch_ready !== 1'b1) begin n_bad++; $display("FAIL post_reset_fr: got %b want 1", fetch_ready); end
    if (uop_valid !== 1'b0) begin n_bad++; $display("FAIL post_reset_uv: got %b want 0", uop_valid); end
    if (dec_insn !== 32'd0) begin n_bad++; $display("FAIL post_reset_insn: got %h want 0", dec_insn); end
    tick();
  endtask

  task automatic test_single();
    drive(0, 0, 1, NOP, 64'h1000, 1, 0, 0);
    n_cmp += 2;
    if (fetch_ready !== 1'b1) begin n_bad++; $display("FAIL single_fr: got %b want 1", fetch_ready); end
    if (uop_valid !== 1'b0) begin n_bad++; $display("FAIL single_nobypass: got %b want 0", uop_valid); end
    tick();
    drive(0, 0, 0, '0, '0, 1, 0, 0);
    n_cmp += 3;
    if (uop_valid !== 1'b1) begin n_bad++; $display("FAIL single_uv: got %b want 1", uop_valid); end
    if (dec_pc !== 64'h1000) begin n_bad++; $display("FAIL single_pc: got %h want 1000", dec_pc); end
    if (dec_insn !== NOP) begin n_bad++; $display("FAIL single_insn: got %h want %h", dec_insn, NOP); end
    tick();
    drive(0, 0, 0, '0, '0, 1, 0, 0);
    n_cmp += 1;
    if (uop_valid !== 1'b0) begin n_bad++; $display("FAIL single_empty: got %b want 0", uop_valid); end
    tick();
  endtask

  task automatic test_full_wrap();
    logic [31:0]   ins [5];
    logic [MW-1:0] pcs [5];
    for (int k = 0; k < 5; k++) begin
      ins[k] = 32'h0000_0093 | (32'(k + 1) << 20);
      pcs[k] = 64'h2000 + 64'(4 * k);
    end
    for (int k = 0; k < 4; k++) begin
      drive(0, 0, 1, ins[k], pcs[k], 0, 0, 0);
      n_cmp++;
      if (fetch_ready !== 1'b1) begin n_bad++; $display("FAIL fill_fr%0d: got %b want 1", k, fetch_ready); end
      tick();
    end
    drive(0, 0, 1, ins[4], pcs[4], 0, 0, 0);
    n_cmp += 2;
    if (fetch_ready !== 1'b0) begin n_bad++; $display("FAIL full_fr: got %b want 0", fetch_ready); end
    if (dec_pc !== pcs[0]) begin n_bad++; $display("FAIL full_head: got %h want %h", dec_pc, pcs[0]); end
    tick();
    drive(0, 0, 1, ins[4], pcs[4], 1, 0, 0);
    n_cmp += 2;
    if (fetch_ready !== 1'b0) begin n_bad++; $display("FAIL full_pop_fr: got %b want 0", fetch_ready); end
    if (uop_valid !== 1'b1) begin n_bad++; $display("FAIL full_pop_uv: got %b want 1", uop_valid); end
    tick();
    drive(0, 0, 1, ins[4], pcs[4], 0, 0, 0);
    n_cmp += 2;
    if (fetch_ready !== 1'b1) begin n_bad++; $display("FAIL refill_fr: got %b want 1", fetch_ready); end
    if (dec_pc !== pcs[1]) begin n_bad++; $display("FAIL refill_head: got %h want %h", dec_pc, pcs[1]); end
    tick();
    for (int k = 1; k < 5; k++) begin
      drive(0, 0, 0, '0, '0, 1, 0, 0);
      n_cmp++;
      if ({uop_valid, dec_insn, dec_pc} !== {1'b1, ins[k], pcs[k]}) begin
        n_bad++; $display("FAIL wrap_order%0d: got %b/%h/%h want 1/%h/%h", k, uop_valid, dec_insn, dec_pc, ins[k], pcs[k]);
      end
      tick();
    end
    drive(0, 0, 0, '0, '0, 1, 0, 0);
    n_cmp++;
    if (uop_valid !== 1'b0) begin n_bad++; $display("FAIL wrap_empty: got %b want 0", uop_valid); end
    tick();
  endtask

  task automatic test_serialize();
    drive(0, 0, 1, RDCYCLE, 64'h3000, 1, 0, 0); tick();
    drive(0, 0, 0, '0, '0, 1, 0, 0);
    n_cmp += 2;
    if (uop_valid !== 1'b0) begin n_bad++; $display("FAIL ser_hold: got %b want 0", uop_valid); end
    if (dec_insn !== RDCYCLE) begin n_bad++; $display("FAIL ser_head: got %h want %h", dec_insn, RDCYCLE); end
    tick();
    // Three drain cycles; a stray retire pulse in the first must be ignored.
    for (int k = 0; k < 3; k++) begin
      drive(0, 0, 0, '0, '0, 1, (k == 2), (k == 0));
      n_cmp++;
      if (uop_valid !== 1'b0) begin n_bad++; $display("FAIL drain_uv%0d: got %b want 0", k, uop_valid); end
      tick();
    end
    drive(0, 0, 1, NOP, 64'h3004, 1, 0, 0);
    n_cmp += 2;
    if (uop_valid !== 1'b1) begin n_bad++; $display("FAIL issue_uv: got %b want 1", uop_valid); end
    if (dec_pc !== 64'h3000) begin n_bad++; $display("FAIL issue_pc: got %h want 3000", dec_pc); end
    tick();
    drive(0, 0, 0, '0, '0, 1, 1, 0);
    n_cmp++;
    if (uop_valid !== 1'b0) begin n_bad++; $display("FAIL wait_uv0: got %b want 0", uop_valid); end
    tick();
    drive(0, 0, 0, '0, '0, 1, 0, 1);
    n_cmp += 2;
    if (uop_valid !== 1'b0) begin n_bad++; $display("FAIL wait_uv1: got %b want 0", uop_valid); end
    if (ser_stall_cycles !== (PERF ? 32'd4 : 32'd0)) begin n_bad++; $display("FAIL stall_mid: got %0d want %0d", ser_stall_cycles, PERF ? 4 : 0); end
    tick();
    drive(0, 0, 0, '0, '0, 1, 0, 0);
    n_cmp += 3;
    if (uop_valid !== 1'b1) begin n_bad++; $display("FAIL resume_uv: got %b want 1", uop_valid); end
    if (dec_pc !== 64'h3004) begin n_bad++; $display("FAIL resume_pc: got %h want 3004", dec_pc); end
    if (ser_stall_cycles !== (PERF ? 32'd5 : 32'd0)) begin n_bad++; $display("FAIL stall_end: got %0d want %0d", ser_stall_cycles, PERF ? 5 : 0); end
    tick();
  endtask

  task automatic test_halt();
    drive(0, 0, 1, EBREAK, 64'h4000, 1, 1, 0); tick();
    drive(0, 0, 1, NOP, 64'h4004, 1, 1, 0);
    n_cmp++;
    if (uop_valid !== 1'b0) begin n_bad++; $display("FAIL halt_hold: got %b want 0", uop_valid); end
    tick();
    drive(0, 0, 0, '0, '0, 1, 1, 0); tick();
    drive(0, 0, 0, '0, '0, 1, 0, 0);
    n_cmp += 2;
    if (uop_valid !== 1'b1) begin n_bad++; $display("FAIL halt_issue: got %b want 1", uop_valid); end
    if (dec_pc !== 64'h4000) begin n_bad++; $display("FAIL halt_issue_pc: got %h want 4000", dec_pc); end
    tick();
    for (int k = 0; k < 10; k++) begin
      drive(0, 0, 0, '0, '0, 1, 1, 1);
      n_cmp++;
      if ({uop_valid, dec_pc} !== {1'b0, 64'h4004}) begin
        n_bad++; $display("FAIL halted%0d: got uv=%b pc=%h want uv=0 pc=4004", k, uop_valid, dec_pc);
      end
      tick();
    end
    drive(0, 1, 1, NOP, 64'h4008, 1, 1, 0);
    n_cmp += 2;
    if (uop_valid !== 1'b0) begin n_bad++; $display("FAIL flush_uv: got %b want 0", uop_valid); end
    if (fetch_ready !== 1'b0) begin n_bad++; $display("FAIL flush_fr: got %b want 0", fetch_ready); end
    tick();
    drive(0, 0, 1, NOP, 64'h4100, 1, 0, 0);
    n_cmp += 2;
    if (fetch_ready !== 1'b1) begin n_bad++; $display("FAIL after_flush_fr: got %b want 1", fetch_ready); end
    if (dec_insn !== 32'd0) begin n_bad++; $display("FAIL after_flush_empty: got %h want 0", dec_insn); end
    tick();
    drive(0, 0, 0, '0, '0, 1, 0, 0);
    n_cmp++;
    if ({uop_valid, dec_pc} !== {1'b1, 64'h4100}) begin n_bad++; $display("FAIL after_flush_run: got %b/%h want 1/4100", uop_valid, dec_pc); end
    tick();
  endtask

  task automatic test_flush_drain();
    drive(0, 0, 1, RDCYCLE, 64'h5000, 0, 0, 0); tick();
    drive(0, 0, 1, NOP, 64'h5004, 0, 0, 0); tick();
    drive(0, 0, 1, NOP, 64'h5008, 0, 0, 0); tick();
    drive(0, 1, 1, NOP, 64'h5010, 1, 0, 0);
    n_cmp += 2;
    if (uop_valid !== 1'b0) begin n_bad++; $display("FAIL fd_uv: got %b want 0", uop_valid); end
    if (fetch_ready !== 1'b0) begin n_bad++; $display("FAIL fd_fr: got %b want 0", fetch_ready); end
    tick();
    for (int k = 0; k < 2; k++) begin
      drive(0, 0, 0, '0, '0, 1, 0, 0);
      n_cmp++;
      if ({uop_valid, fetch_ready, dec_insn} !== {1'b0, 1'b1, 32'd0}) begin
        n_bad++; $display("FAIL fd_after%0d: got uv=%b fr=%b insn=%h want 0/1/0", k, uop_valid, fetch_ready, dec_insn);
      end
      tick();
    end
  endtask

  task automatic test_reset_midser();
    drive(0, 0, 1, RDCYCLE, 64'h6000, 1, 1, 0); tick();
    drive(0, 0, 1, NOP, 64'h6004, 1, 1, 0); tick();
    drive(0, 0, 1, NOP, 64'h6008, 1, 1, 0); tick();
    drive(0, 0, 0, '0, '0, 1, 0, 0);
    n_cmp++;
    if (uop_valid !== 1'b1) begin n_bad++; $display("FAIL rm_issue: got %b want 1", uop_valid); end
    tick();
    drive(1, 0, 1, NOP, 64'h600C, 1, 1, 1);
    n_cmp += 2;
    if (dec_pc !== 64'h6004) begin n_bad++; $display("FAIL rm_wait_head: got %h want 6004", dec_pc); end
    if ({uop_valid, fetch_ready} !== 2'b00) begin n_bad++; $display("FAIL rm_reset: got %b want 00", {uop_valid, fetch_ready}); end
    tick();
    drive(0, 0, 0, '0, '0, 1, 0, 0);
    n_cmp++;
    if ({uop_valid, fetch_ready, dec_insn, ser_stall_cycles} !== {1'b0, 1'b1, 32'd0, 32'd0}) begin
      n_bad++; $display("FAIL rm_after: got uv=%b fr=%b insn=%h stall=%0d want 0/1/0/0", uop_valid, fetch_ready, dec_insn, ser_stall_cycles);
    end
    tick();
  endtask

  task automatic test_random();
    logic [31:0] ins;
    int sel;
    drive(1, 0, 0, '0, '0, 0, 0, 0); tick();
    for (int c = 0; c < 800; c++) begin
      sel = $urandom_range(99);
      if (sel < 70)      ins = {$urandom_range(4095), 20'h00093};
      else if (sel < 85) ins = RDCYCLE;
      else if (sel < 93) ins = EBREAK;
      else               ins = 32'h0000_0073;
      drive(($urandom_range(199) == 0), ($urandom_range(24) == 0), ($urandom_range(9) < 7), ins,
            {$urandom, $urandom}, ($urandom_range(9) < 6), ($urandom_range(9) < 4), ($urandom_range(9) < 3));
      n_cmp++;
      if ({uop_valid, fetch_ready, dec_insn, dec_pc, ser_stall_cycles} !== {exp_uv, exp_fr, exp_insn, exp_pc, exp_stall}) begin
        n_bad++;
        $display("FAIL rand c%0d: got uv=%b fr=%b insn=%h pc=%h stall=%0d want uv=%b fr=%b insn=%h pc=%h stall=%0d",
                 c, uop_valid, fetch_ready, dec_insn, dec_pc, ser_stall_cycles, exp_uv, exp_fr, exp_insn, exp_pc, exp_stall);
      end
      tick();
    end
  endtask

  initial begin
    test_reset();
    test_single();
    test_full_wrap();
    test_serialize();
    test_halt();
    test_flush_drain();
    test_reset_midser();
    test_random();
    $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_bad);
    $finish;
  end

endmodule
